// File: rtl/updi_echo_filter_pkg.sv
// Shared UPDI link types and constants for the receive path.
// Holds receiver/filter state enums, data width and the SYNCH byte.
package updi_pkg;

    localparam int UPDI_DATA_BITS = 8;
    localparam logic [7:0] UPDI_SYNCH = 8'h55;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    typedef enum logic {
        RXF_IDLE,
        RXF_COLLECT
    } rxf_state_t;

endpackage

// File: rtl/updi_echo_filter_sync_fifo.sv
// Synchronous FIFO, power-of-2 DEPTH, push+pop allowed even when full.
// Ports: clk, rst (sync, active-high), i_push/i_data, i_pop, o_data
// (head), o_empty, o_full. Push on full without pop is dropped.
module sync_fifo
    import updi_pkg::*;
#(
    parameter int WIDTH = UPDI_DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = ((r_wr - r_rd) == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // a pop frees the slot, so a full queue still accepts a push
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/updi_echo_filter.sv
// UPDI echo filter: strips self-echoes from rx, forwards response bytes.
// Ports: tx_sent/tx_sent_data (echo push), rx_data/rx_data_valid/
// rx_error (receiver), expect_start/expect_len (collection request),
// resp_data/resp_valid/resp_ready (response FIFO), collecting, and
// 1-clk pulses echo_err, parity_err, unsolicited, timeout, overflow.
// Macro UPDI_ECHO_CHECK_EN: compare echoes against sent bytes.
module updi_echo_filter
    import updi_pkg::*;
#(
    parameter int DATA_BITS      = UPDI_DATA_BITS,
    parameter int ECHO_DEPTH     = 4,
    parameter int RESP_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_sent,
    input  logic [DATA_BITS-1:0] tx_sent_data,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_data_valid,
    input  logic                 rx_error,
    input  logic                 expect_start,
    input  logic [7:0]           expect_len,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 collecting,
    output logic                 echo_err,
    output logic                 parity_err,
    output logic                 unsolicited,
    output logic                 timeout,
    output logic                 overflow
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    rxf_state_t       r_state;
    logic [7:0]       r_remaining;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_parity_err;
    logic             r_unsolicited;
    logic             r_timeout;
    logic             r_overflow;

    logic w_rx_ev;
    logic w_echo_empty;
    logic w_echo_full;
    logic w_echo_pop;
    logic w_echo_ovf;
    logic w_coll_ev;
    logic w_unsol;
    logic w_resp_push;
    logic w_resp_pop;
    logic w_resp_empty;
    logic w_resp_full;
    logic w_resp_ovf;

    assign w_rx_ev    = rx_data_valid || rx_error;
    // classification uses the echo queue before any same-cycle push
    assign w_echo_pop = w_rx_ev && !w_echo_empty;
    assign w_echo_ovf = tx_sent && w_echo_full && !w_echo_pop;

    assign w_coll_ev = w_rx_ev && w_echo_empty
                     && (r_state == RXF_COLLECT);
    assign w_unsol   = w_rx_ev && w_echo_empty
                     && (r_state == RXF_IDLE);

    assign w_resp_push = w_coll_ev && rx_data_valid && !rx_error;
    assign w_resp_pop  = !w_resp_empty && resp_ready;
    assign w_resp_ovf  = w_resp_push && w_resp_full && !w_resp_pop;

`ifdef UPDI_ECHO_CHECK_EN
    logic [DATA_BITS-1:0] w_echo_head;
    logic                 w_echo_err;
    logic                 r_echo_err;

    assign w_echo_err = w_echo_pop
                      && (rx_error || (rx_data != w_echo_head));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (ECHO_DEPTH)
    ) u_echo_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_sent),
        .i_data  (tx_sent_data),
        .i_pop   (w_echo_pop),
        .o_data  (w_echo_head),
        .o_empty (w_echo_empty),
        .o_full  (w_echo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) r_echo_err <= 1'b0;
        else     r_echo_err <= w_echo_err;
    end

    assign echo_err = r_echo_err;
`else
    // only the echo count matters; storage is a single dummy bit
    logic w_echo_head_unused;
    logic w_unused_tx;

    assign w_unused_tx = ^{tx_sent_data, w_echo_head_unused};

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (ECHO_DEPTH)
    ) u_echo_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_sent),
        .i_data  (1'b0),
        .i_pop   (w_echo_pop),
        .o_data  (w_echo_head_unused),
        .o_empty (w_echo_empty),
        .o_full  (w_echo_full)
    );

    assign echo_err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RESP_DEPTH)
    ) u_resp_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_resp_push),
        .i_data  (rx_data),
        .i_pop   (w_resp_pop),
        .o_data  (resp_data),
        .o_empty (w_resp_empty),
        .o_full  (w_resp_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RXF_IDLE;
            r_remaining   <= 8'd0;
            r_tmo_cnt     <= '0;
            r_parity_err  <= 1'b0;
            r_unsolicited <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_parity_err  <= (w_coll_ev || w_unsol) && rx_error;
            r_unsolicited <= w_unsol;
            r_overflow    <= w_echo_ovf || w_resp_ovf;
            r_timeout     <= 1'b0;
            if (expect_start && (expect_len != 8'd0)) begin
                r_state     <= RXF_COLLECT;
                r_remaining <= expect_len;
                r_tmo_cnt   <= '0;
            end else if (r_state == RXF_COLLECT) begin
                if (w_coll_ev) begin
                    r_tmo_cnt   <= '0;
                    r_remaining <= r_remaining - 8'd1;
                    if (r_remaining == 8'd1) r_state <= RXF_IDLE;
                end else if (w_echo_empty) begin
                    // turnaround measured only after the last echo
                    if (r_tmo_cnt == TMO_LAST) begin
                        r_state     <= RXF_IDLE;
                        r_remaining <= 8'd0;
                        r_tmo_cnt   <= '0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign resp_valid  = !w_resp_empty;
    assign collecting  = (r_state == RXF_COLLECT);
    assign parity_err  = r_parity_err;
    assign unsolicited = r_unsolicited;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_updi_echo_filter.sv
// Directed bench for updi_echo_filter: vector table plus hand sequences
// for timeout, response overflow and mid-collection reset.
module tb_updi_echo_filter;

    localparam int TMO = 20;

`ifdef UPDI_ECHO_CHECK_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_sent;
    logic [7:0] tx_sent_data;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_error;
    logic       expect_start;
    logic [7:0] expect_len;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;
    logic       collecting;
    logic       echo_err;
    logic       parity_err;
    logic       unsolicited;
    logic       timeout;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updi_echo_filter #(
        .DATA_BITS      (8),
        .ECHO_DEPTH     (4),
        .RESP_DEPTH     (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_sent       (tx_sent),
        .tx_sent_data  (tx_sent_data),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_error      (rx_error),
        .expect_start  (expect_start),
        .expect_len    (expect_len),
        .resp_data     (resp_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .collecting    (collecting),
        .echo_err      (echo_err),
        .parity_err    (parity_err),
        .unsolicited   (unsolicited),
        .timeout       (timeout),
        .overflow      (overflow)
    );

    // {echo_err, parity_err, unsolicited, timeout, overflow, rv, coll}
    typedef struct {
        logic       tx;
        logic [7:0] txd;
        logic       rxv;
        logic       rxe;
        logic [7:0] rxd;
        logic       es;
        logic [7:0] el;
        logic       rdy;
        logic [6:0] exp;
        logic       chk_d;
        logic [7:0] exp_d;
    } vec_t;

    function automatic logic [6:0] outs();
        return {echo_err, parity_err, unsolicited, timeout,
                overflow, resp_valid, collecting};
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(logic tx, logic [7:0] txd, logic rxv,
                       logic rxe, logic [7:0] rxd, logic es,
                       logic [7:0] el);
        tx_sent       = tx;
        tx_sent_data  = txd;
        rx_data_valid = rxv;
        rx_error      = rxe;
        rx_data       = rxd;
        expect_start  = es;
        expect_len    = el;
        @(posedge clk);
        #1;
        tx_sent       = 1'b0;
        rx_data_valid = 1'b0;
        rx_error      = 1'b0;
        expect_start  = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic rxb(logic [7:0] d);
        cyc(0, 8'h00, 1, 0, d, 0, 8'h00);
    endtask

    function automatic vec_t v(logic tx, logic [7:0] txd, logic rxv,
                               logic rxe, logic [7:0] rxd, logic es,
                               logic [7:0] el, logic rdy,
                               logic [6:0] exp, logic chk_d,
                               logic [7:0] exp_d);
        vec_t r;
        r.tx = tx;   r.txd = txd; r.rxv = rxv; r.rxe = rxe;
        r.rxd = rxd; r.es = es;   r.el = el;   r.rdy = rdy;
        r.exp = exp; r.chk_d = chk_d; r.exp_d = exp_d;
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        bit bad;

        tbl[0]  = v(1, 8'h55, 0, 0, 8'h00, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[1]  = v(1, 8'h80, 0, 0, 8'h00, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[2]  = v(0, 8'h00, 1, 0, 8'h55, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[3]  = v(0, 8'h00, 1, 0, 8'h80, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[4]  = v(0, 8'h00, 0, 0, 8'h00, 1, 8'd1, 0,
                    7'b0000001, 0, 8'h00);
        tbl[5]  = v(0, 8'h00, 1, 0, 8'h30, 0, 8'd0, 0,
                    7'b0000010, 1, 8'h30);
        tbl[6]  = v(0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 1, 7'b0, 0, 8'h00);
        tbl[7]  = v(0, 8'h00, 1, 0, 8'h7F, 0, 8'd0, 0,
                    7'b0010000, 0, 8'h00);
        tbl[8]  = v(1, 8'hA5, 0, 0, 8'h00, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[9]  = v(0, 8'h00, 1, 0, 8'hA4, 0, 8'd0, 0,
                    {ECHO_EN, 6'b0}, 0, 8'h00);
        tbl[10] = v(0, 8'h00, 0, 0, 8'h00, 1, 8'd1, 0,
                    7'b0000001, 0, 8'h00);
        tbl[11] = v(0, 8'h00, 0, 1, 8'h00, 0, 8'd0, 0,
                    7'b0100000, 0, 8'h00);
        tbl[12] = v(0, 8'h00, 0, 1, 8'h00, 0, 8'd0, 0,
                    7'b0110000, 0, 8'h00);
        tbl[13] = v(0, 8'h00, 0, 0, 8'h00, 1, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[14] = v(1, 8'h12, 0, 0, 8'h00, 0, 8'd0, 0, 7'b0, 0, 8'h00);
        tbl[15] = v(0, 8'h00, 0, 0, 8'h00, 1, 8'd1, 0,
                    7'b0000001, 0, 8'h00);
        tbl[16] = v(0, 8'h00, 1, 0, 8'h12, 0, 8'd0, 0,
                    7'b0000001, 0, 8'h00);
        tbl[17] = v(0, 8'h00, 1, 0, 8'h44, 0, 8'd0, 0,
                    7'b0000010, 1, 8'h44);
        tbl[18] = v(0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 1, 7'b0, 0, 8'h00);

        rst = 1'b1;
        resp_ready = 1'b0;
        tx_sent = 1'b0; tx_sent_data = '0;
        rx_data = '0; rx_data_valid = 1'b0; rx_error = 1'b0;
        expect_start = 1'b0; expect_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        rst = 1'b0;
        idle();
        chk("post_reset_outs", 32'(outs()), 32'h0);

        for (int i = 0; i < 19; i++) begin
            resp_ready = tbl[i].rdy;
            cyc(tbl[i].tx, tbl[i].txd, tbl[i].rxv, tbl[i].rxe,
                tbl[i].rxd, tbl[i].es, tbl[i].el);
            chk($sformatf("vec%0d_outs", i), 32'(outs()),
                32'(tbl[i].exp));
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d_data", i), 32'(resp_data),
                    32'(tbl[i].exp_d));
        end
        resp_ready = 1'b0;

        // timeout after one of two bytes
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 8'd2);
        chk("tmo_start", 32'(collecting), 32'h1);
        rxb(8'h11);
        chk("tmo_byte", 32'({resp_valid, collecting}), 32'h3);
        bad = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            idle();
            if (timeout || !collecting) bad = 1'b1;
        end
        chk("tmo_early", 32'(bad), 32'h0);
        idle();
        chk("tmo_pulse", 32'({timeout, collecting}), 32'h2);
        chk("tmo_keep_data", 32'(resp_data), 32'h11);
        idle();
        chk("tmo_one_clk", 32'({timeout, resp_valid}), 32'h1);
        resp_ready = 1'b1;
        idle();
        resp_ready = 1'b0;
        chk("tmo_drained", 32'(resp_valid), 32'h0);

        // response FIFO overflow on the 17th byte
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 8'd17);
        bad = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rxb(8'h60 + 8'(i));
            if (i < 16 && (overflow || !collecting)) bad = 1'b1;
        end
        chk("ovf_early", 32'(bad), 32'h0);
        chk("ovf_pulse", 32'({overflow, resp_valid, collecting}),
            32'h6);
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_data%0d", i),
                32'({resp_valid, resp_data}),
                32'({1'b1, 8'h60 + 8'(i)}));
            idle();
        end
        chk("ovf_empty", 32'(resp_valid), 32'h0);
        resp_ready = 1'b0;

        // reset while collecting with three bytes queued
        cyc(0, 8'h00, 0, 0, 8'h00, 1, 8'd5);
        rxb(8'hA0);
        rxb(8'hA1);
        rxb(8'hA2);
        chk("rst_pre", 32'({resp_valid, collecting}), 32'h3);
        rst = 1'b1;
        cyc(1, 8'h99, 0, 1, 8'h00, 0, 8'd0);
        chk("rst_outs", 32'(outs()), 32'h0);
        rst = 1'b0;
        idle();
        chk("rst_after", 32'(outs()), 32'h0);
        rxb(8'h42);
        chk("rst_echo_cleared", 32'(outs()), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
